word_byte_serializer: RTL and testbench
=======================================

# word_byte_serializer

Reads a 32-bit word from an upstream register stage and emits it as four 8-bit beats over a valid/ready stream, least-significant byte first. It is the read side of the datapath's write-enabled 32-bit registers: the register holds the word and this block drains it to a narrow sink (debug/UART bridge, byte-wide memory port). It supports back-to-back words with no bubble between the last beat of one word and the first beat of the next.

## Interface
- WORD_WIDTH, 32, width of the parallel input word
- BEAT_WIDTH, 8, width of each output beat; WORD_WIDTH must be an integer multiple of it
- BEATS, WORD_WIDTH/BEAT_WIDTH (derived, not overridable), beats per word
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  upstream word available
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WORD_WIDTH  word to serialize
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  sink accepts the beat this cycle
- out_data  output  BEAT_WIDTH  current beat
- out_last  output  1  current beat is the final beat of its word
- busy  output  1  a word is held (state SEND)

## Operation
- States: IDLE (no word held), SEND (word held, beats pending). Encoding: IDLE=0, SEND=1.
- Word accept: in_valid && in_ready at an edge. Beat transfer: out_valid && out_ready at an edge.
- in_ready = (state==IDLE) || (state==SEND && out_ready && out_last). Combinational path out_ready -> in_ready is intentional.
- IDLE: on word accept, load shift register with in_data, beat counter <= 0, go to SEND.
- SEND: out_valid=1; out_data = shift_reg[BEAT_WIDTH-1:0]; out_last = (count==BEATS-1).
  - Beat transfer, not last: shift right by BEAT_WIDTH (zero fill), count+1.
  - Beat transfer, last, with simultaneous word accept: reload shift register, count <= 0, stay in SEND.
  - Beat transfer, last, no accept: go IDLE, count <= 0.
  - No transfer: shift register, count, out_data, out_last held stable.
- IDLE: out_valid=0, out_last=0, out_data=0.
- in_data ignored whenever in_ready=0; in_valid may drop at any time without effect.
- busy = (state==SEND).

## Timing
- Reset (rst=0, any time, asynchronous): state IDLE, count 0, shift register 0; outputs out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1 (after rst released, combinationally from IDLE). A word mid-transfer is discarded; no partial beats after release.
- Latency: word accepted at edge N -> first beat on out_data in the cycle after edge N.
- Throughput: with out_ready held 1 and in_valid held 1, one beat per cycle, BEATS cycles per word, zero idle cycles between words.
- Backpressure: out_ready=0 holds all outputs unchanged for any number of cycles.
- out_valid never drops in SEND without a beat transfer.
- Count width: clog2(BEATS), minimum 1 bit; wraps only via explicit reset to 0, never by overflow.

## Structure
- Shared package/header (serializer_defs): state encodings IDLE/SEND, default WORD_WIDTH/BEAT_WIDTH, BEATS derivation.
- One sub-module: word_shift_register (parallel load, right shift by BEAT_WIDTH, hold, asynchronous active-low reset to 0); FSM and counter stay in the top module.
- Elaboration check: WORD_WIDTH % BEAT_WIDTH != 0 is a fatal error.

## Test plan
- Reset: hold rst=0 for 3 cycles -> out_valid=0, out_data=0, out_last=0, busy=0; after release in_ready=1.
- Single word: in_data=0x12345678, out_ready=1 -> beats 0x78,0x56,0x34,0x12 on 4 consecutive cycles, out_last only on 0x12, then out_valid=0.
- Backpressure: word 0xDEADBEEF, out_ready toggling 1,0,0,1,... -> beats EF,BE,AD,DE in order, each held stable while out_ready=0.
- Back-to-back: words 0xAABBCCDD then 0x11223344 with in_valid and out_ready held 1 -> 8 contiguous beats DD,CC,BB,AA,44,33,22,11; in_ready=1 exactly on cycles of out_last transfer.
- Reset mid-word: after 2 beats of 0xCAFEF00D, pulse rst=0 -> outputs zero immediately (asynchronously); after release no remaining beats appear, next word 0x00000001 yields 01,00,00,00.
- Ignored input: in_valid=1 with changing in_data while in SEND and out_ready=0 -> serialized word unchanged.

Source files
------------

// File: rtl/serializer_defs.sv
// serializer_defs: shared state encodings, default widths and beat-count helpers
package serializer_defs;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_BEAT_WIDTH = 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    function automatic int beats_of(input int ww, input int bw);
        return ww / bw;
    endfunction
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction
endpackage

// File: rtl/word_shift_register.sv
// word_shift_register: word register with parallel load and beat-wide right shift
module word_shift_register
    import serializer_defs::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [BEAT_WIDTH-1:0] beat_o
);
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    always_comb sr_d = load_i ? data_i : shift_i ? (sr_q >> BEAT_WIDTH) : sr_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    assign beat_o = sr_q[BEAT_WIDTH-1:0];
endmodule

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: drains a parallel word as LSB-first beats over valid/ready
module word_byte_serializer
    import serializer_defs::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int BEATS = beats_of(WORD_WIDTH, BEAT_WIDTH);
    localparam int CW    = cnt_width(BEATS);

    if (WORD_WIDTH % BEAT_WIDTH != 0) begin : g_bad_width
        $fatal(1, "WORD_WIDTH must be a multiple of BEAT_WIDTH");
    end

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last, xfer, accept;
    logic [BEAT_WIDTH-1:0] beat;

    assign busy      = state_q == SEND;
    assign last      = busy && cnt_q == CW'(BEATS - 1);
    assign xfer      = busy && out_ready;
    // out_ready feeds in_ready so the next word loads on the last beat with no bubble
    assign in_ready  = !busy || (xfer && last);
    assign accept    = in_valid && in_ready;
    assign out_valid = busy;
    assign out_last  = last;
    assign out_data  = busy ? beat : '0;

    always_comb begin
        state_d = accept ? SEND : (xfer && last) ? IDLE : state_q;
        cnt_d   = (accept || (xfer && last)) ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end

    word_shift_register #(.WORD_WIDTH(WORD_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) u_sr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (xfer && !last),
        .data_i  (in_data),
        .beat_o  (beat)
    );
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed scoreboard bench for word_byte_serializer
module tb_word_byte_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    word_byte_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sb.push_back({i == 3, w[8*i +: 8]});
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, sb.size(), 0);
    endtask

    // Every beat presented is compared against the scoreboard head; popped on transfer
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("in_ready", in_ready, out_valid ? (out_ready && out_last) : 1'b1);
            if (out_valid) begin
                if (sb.size() == 0) chk("spurious_beat", {24'd0, out_data}, 32'hffff_ffff);
                else begin
                    chk("beat_data", out_data, sb[0][7:0]);
                    chk("beat_last", out_last, sb[0][8]);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // single word
        out_ready = 1'b1;
        push_word(32'h12345678);
        in_valid = 1'b1; in_data = 32'h12345678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 8'h78);
        drain("single_drain", 20);
        @(negedge clk);
        chk("single_idle", out_valid, 0);

        // backpressure with out_ready pattern 1,0,0,1
        @(posedge clk);
        #1;
        push_word(32'hDEADBEEF);
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            out_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        chk("bp_drain", sb.size(), 0);
        @(negedge clk);
        chk("bp_idle", out_valid, 0);

        // back-to-back words, no bubble
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_word(32'hAABBCCDD);
        push_word(32'h11223344);
        in_valid = 1'b1; in_data = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        in_data = 32'h11223344;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", out_valid, 1);
            @(posedge clk);
            #1;
            if (i == 3) in_valid = 1'b0;
        end
        chk("b2b_drain", sb.size(), 0);
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        // asynchronous reset mid-word
        @(posedge clk);
        #1;
        push_word(32'hCAFEF00D);
        in_valid = 1'b1; in_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        push_word(32'h00000001);
        in_valid = 1'b1; in_data = 32'h00000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("post_rst_drain", 20);

        // in_data changes while held word is stalled must be ignored
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_word(32'h01020304);
        in_valid = 1'b1; in_data = 32'h01020304;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            @(posedge clk);
            #1;
            chk("ign_hold_data", out_data, 8'h04);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("ign_drain", 20);
        @(negedge clk);
        chk("ign_idle", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
